cic_dec_ctrl: RTL and testbench

Decimation sequencer for the CIC chain in the DDC. It counts accepted integrator-rate samples and issues the one-cycle `integ_flag` strobe that clocks every comb stage. It also discards comb warm-up outputs and flags valid decimated samples to the downstream FIR mux. Rate changes are applied safely, only at a decimation boundary.

---
 rtl/cic_dec_ctrl_pkg.sv | 8 +
 rtl/cic_dec_ctrl_dec_rate_counter.sv | 40 ++++
 rtl/cic_dec_ctrl.sv | 72 +++++++
 tb/tb_cic_dec_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cic_dec_ctrl_pkg.sv
// cic_dec_ctrl_pkg: shared DDC decimation-control types and default constants
package cic_dec_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  localparam int DEF_RATEWIDTH = 8;
  localparam int DEF_WARMUP = 8;
  localparam int DEF_DEFRATE = 16;
  localparam int MIN_RATE = 2;
endpackage

// File: rtl/cic_dec_ctrl_dec_rate_counter.sv
// dec_rate_counter: modulo-R sample counter with pending-rate register, applies pending rate on wrap
module dec_rate_counter import cic_dec_ctrl_pkg::*; #(
  parameter int RATEWIDTH = DEF_RATEWIDTH,
  parameter int DEFRATE = DEF_DEFRATE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 active,
  input  logic                 idle,
  input  logic                 in_valid,
  input  logic                 load,
  input  logic [RATEWIDTH-1:0] rate_in,
  output logic                 wrap,
  output logic                 apply,
  output logic [RATEWIDTH-1:0] rate_active
);
  logic [RATEWIDTH-1:0] cnt_q, cnt_d, rate_q, rate_d, pend_q, pend_d;
  logic pend_vld_q, pend_vld_d;
  always_comb begin
    wrap = active && in_valid && cnt_q == rate_q - RATEWIDTH'(1);
    apply = wrap && pend_vld_q;
    cnt_d = (!active || wrap) ? '0 : cnt_q + RATEWIDTH'(in_valid);
    rate_d = apply ? pend_q : (idle && load) ? rate_in : rate_q;
    pend_d = (load && !idle) ? rate_in : pend_q;
    pend_vld_d = active && ((load && !idle) || (pend_vld_q && !apply));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= '0;
      rate_q <= RATEWIDTH'(DEFRATE);
      pend_q <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rate_q <= rate_d;
      pend_q <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  assign rate_active = rate_q;
endmodule

// File: rtl/cic_dec_ctrl.sv
// cic_dec_ctrl: CIC decimation sequencer issuing comb strobes, warm-up masking and safe rate changes
module cic_dec_ctrl import cic_dec_ctrl_pkg::*; #(
  parameter int RATEWIDTH = DEF_RATEWIDTH,
  parameter int WARMUP = DEF_WARMUP,
  parameter int DEFRATE = DEF_DEFRATE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic [RATEWIDTH-1:0] rate_in,
  input  logic                 rate_load,
  output logic                 integ_flag,
  output logic                 dec_valid,
  output logic [RATEWIDTH-1:0] rate_active,
  output logic                 cfg_err,
  output logic                 busy
);
  localparam int WW = $clog2(WARMUP + 1);
  state_t state_q, state_d;
  logic [WW-1:0] warm_q, warm_d;
  logic integ_flag_q, integ_flag_d, vld_q, vld_d, dec_valid_q, dec_valid_d;
  logic cfg_err_q, cfg_err_d, busy_q, busy_d;
  logic legal, wrap, apply;
  dec_rate_counter #(.RATEWIDTH(RATEWIDTH), .DEFRATE(DEFRATE)) u_cnt (
    .clk(clk),
    .rst(rst),
    .active(enable && state_q != IDLE),
    .idle(state_q == IDLE),
    .in_valid(in_valid),
    .load(rate_load && legal),
    .rate_in(rate_in),
    .wrap(wrap),
    .apply(apply),
    .rate_active(rate_active)
  );
  always_comb begin
    legal = rate_in >= RATEWIDTH'(MIN_RATE);
    warm_d = (!enable || state_q == IDLE || apply) ? '0
           : (wrap && warm_q != WW'(WARMUP)) ? warm_q + WW'(1) : warm_q;
    state_d = !enable ? IDLE
            : (state_q == IDLE || apply) ? FILL
            : (state_q == FILL && warm_d == WW'(WARMUP)) ? RUN : state_q;
    integ_flag_d = wrap;
    vld_d = wrap && state_q == RUN;
    dec_valid_d = vld_q && enable && state_q == RUN;
    cfg_err_d = rate_load && !legal;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      warm_q <= '0;
      integ_flag_q <= 1'b0;
      vld_q <= 1'b0;
      dec_valid_q <= 1'b0;
      cfg_err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q <= warm_d;
      integ_flag_q <= integ_flag_d;
      vld_q <= vld_d;
      dec_valid_q <= dec_valid_d;
      cfg_err_q <= cfg_err_d;
      busy_q <= busy_d;
    end
  assign integ_flag = integ_flag_q;
  assign dec_valid = dec_valid_q;
  assign cfg_err = cfg_err_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_cic_dec_ctrl.sv
// tb_cic_dec_ctrl: directed and random checks of cic_dec_ctrl against a behavioural model
module tb_cic_dec_ctrl;
  localparam int RW = 8, WU = 8, DR = 16;
  logic clk = 0, rst = 1, enable = 0, in_valid = 0, rate_load = 0;
  logic [RW-1:0] rate_in = '0;
  logic integ_flag, dec_valid, cfg_err, busy;
  logic [RW-1:0] rate_active;
  int checks = 0, failures = 0;
  bit m_on, m_tag, e_flag, e_dv, e_cfg, e_busy, prev_flag;
  int m_n, m_rate, m_pend, m_ns;
  int n_flag, n_dv, n_cfg, t, first_flag, last_flag, gap_bad;
  always #5 clk = ~clk;
  cic_dec_ctrl #(.RATEWIDTH(RW), .WARMUP(WU), .DEFRATE(DR)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .rate_in(rate_in),
    .rate_load(rate_load), .integ_flag(integ_flag), .dec_valid(dec_valid),
    .rate_active(rate_active), .cfg_err(cfg_err), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_on = 0; m_tag = 0; m_n = 0; m_rate = DR; m_pend = -1; m_ns = 0;
    e_flag = 0; e_dv = 0; e_cfg = 0; e_busy = 0; prev_flag = 0;
  endtask
  // One clock edge of the decimator described in samples, strobes and pending rates.
  task automatic model_edge(input bit en, input bit iv, input bit rl, input int ri);
    bit legal, strobe;
    legal = rl && ri >= 2;
    e_cfg = rl && ri < 2;
    e_dv = m_tag && en;
    strobe = m_on && en && iv && (m_n + 1 == m_rate);
    m_tag = 0;
    if (!m_on && legal) m_rate = ri;
    if (!en) begin
      m_on = 0; m_n = 0; m_ns = 0; m_pend = -1;
    end else if (!m_on) begin
      m_on = 1; m_n = 0; m_ns = 0;
    end else begin
      if (iv) m_n++;
      if (strobe) begin
        m_n = 0;
        if (m_pend >= 0) begin
          m_rate = m_pend; m_pend = -1; m_ns = 0;
        end else begin
          m_tag = m_ns >= WU; m_ns++;
        end
      end
      if (legal) m_pend = ri;
    end
    e_flag = strobe;
    e_busy = m_on;
  endtask
  task automatic step(input bit en, input bit iv, input bit rl = 0, input int ri = 0);
    enable = en; in_valid = iv; rate_load = rl; rate_in = ri[RW-1:0];
    model_edge(en, iv, rl, ri);
    @(posedge clk); #1;
    t++;
    chk("integ_flag", integ_flag, e_flag);
    chk("dec_valid", dec_valid, e_dv);
    chk("cfg_err", cfg_err, e_cfg);
    chk("busy", busy, e_busy);
    chk("rate_active", rate_active, m_rate);
    if (prev_flag) chk("no_back_to_back", integ_flag, 0);
    prev_flag = integ_flag;
    if (integ_flag === 1'b1) begin
      if (first_flag < 0) first_flag = t;
      if (last_flag >= 0 && t - last_flag != 12) gap_bad++;
      last_flag = t;
      n_flag++;
    end
    if (dec_valid === 1'b1) n_dv++;
    if (cfg_err === 1'b1) n_cfg++;
    rate_load = 0;
  endtask
  task automatic clr_stats();
    t = 0; n_flag = 0; n_dv = 0; n_cfg = 0; first_flag = -1; last_flag = -1; gap_bad = 0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_flag"}, integ_flag, 0);
    chk({tag, "_dv"}, dec_valid, 0);
    chk({tag, "_cfg"}, cfg_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rate"}, rate_active, DR);
  endtask
  initial begin
    model_reset();
    clr_stats();
    #1 rst = 0;
    #1 chk_reset_outputs("reset");
    @(negedge clk) rst = 1;
    step(1, 1);
    clr_stats();
    for (int i = 0; i < 161; i++) step(1, 1);
    chk("r16_first_flag_step", first_flag, 16);
    chk("r16_flag_count", n_flag, 10);
    chk("r16_dv_count", n_dv, 2);
    for (int i = 0; i < 100 && m_n != 7; i++) step(1, 1);
    step(1, 1, 1, 5);
    clr_stats();
    for (int i = 0; i < 40 && n_flag == 0; i++) step(1, 1);
    chk("r5_old_rate_strobe_delay", t, 8);
    chk("r5_rate_active", rate_active, 5);
    clr_stats();
    for (int i = 0; i < 51; i++) step(1, 1);
    chk("r5_flag_count", n_flag, 10);
    chk("r5_dv_count", n_dv, 2);
    chk("r5_busy", busy, 1);
    clr_stats();
    step(1, 1, 1, 1);
    step(1, 1, 1, 0);
    step(1, 1);
    chk("illegal_cfg_count", n_cfg, 2);
    chk("illegal_rate_kept", rate_active, 5);
    step(1, 1, 1, 4);
    for (int i = 0; i < 20 && m_rate != 4; i++) step(1, 1);
    clr_stats();
    for (int i = 0; i < 48; i++) step(1, i % 3 == 0);
    chk("r4_sparse_flags", n_flag, 4);
    chk("r4_sparse_gap", gap_bad, 0);
    for (int i = 0; i < 400; i++) begin
      bit rl;
      rl = $urandom_range(0, 19) == 0;
      step($urandom_range(0, 99) != 0, 1'($urandom), rl, rl ? int'($urandom_range(0, 7)) : 0);
    end
    step(1, 1, 1, 2);
    for (int i = 0; i < 40 && !(m_on && m_rate == 2 && m_pend < 0); i++) step(1, 1);
    clr_stats();
    for (int i = 0; i < 20; i++) step(1, 1);
    chk("r2_flag_count", n_flag, 10);
    for (int i = 0; i < 10 && !(m_on && m_n + 1 == m_rate); i++) step(1, 1);
    clr_stats();
    step(0, 1);
    chk("drop_enable_flag", integ_flag, 0);
    step(0, 0);
    step(0, 0);
    chk("drop_enable_dv_count", n_dv, 0);
    chk("drop_enable_busy", busy, 0);
    for (int i = 0; i < 6; i++) step(1, 1);
    #2 rst = 0;
    model_reset();
    #1 chk_reset_outputs("async_reset");
    @(negedge clk) rst = 1;
    step(0, 0);
    chk_reset_outputs("post_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
